// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between three requesters
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req_i     per-requester request (0 fetch, 1 load/store, 2 host), held until gnt
//   sel_o     select for the external address/wdata/we mux3to1
//   gnt_o     one-hot grant, one-cycle pulse alongside mem_en_o
//   mem_en_o  memory access strobe
//   rvalid_o  one-hot read-data-valid, MEM_LAT cycles after mem_en_o
//   busy_o    high while a transaction is in flight
// Config: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise
//   fixed priority 0 > 1 > 2.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_i,
    output logic [1:0] sel_o,
    output logic [2:0] gnt_o,
    output logic       mem_en_o,
    output logic [2:0] rvalid_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] lat_q;
    logic [1:0]    last_q;
    logic [1:0]    win_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] c1_d, c2_d;
    // scan last+1, last+2, then last itself (mod 3)
    always_comb begin
        c1_d  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        c2_d  = (c1_d == 2'd2) ? 2'd0 : c1_d + 2'd1;
        win_d = req_i[c1_d] ? c1_d : req_i[c2_d] ? c2_d : last_q;
    end
`else
    // the last_q fallback only applies when nothing requests, where it is unused
    always_comb win_d = req_i[0] ? 2'd0 : req_i[1] ? 2'd1 : req_i[2] ? 2'd2 : last_q;
`endif
    // lat_q counts remaining memory cycles; sel_o holds the winner into IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_o    <= 2'd0;
            gnt_o    <= 3'b000;
            mem_en_o <= 1'b0;
            rvalid_o <= 3'b000;
            busy_o   <= 1'b0;
            lat_q    <= '0;
            last_q   <= 2'd2;
        end else begin
            case (state_q)
                IDLE: if (|req_i) begin
                    state_q  <= ISSUE;
                    sel_o    <= win_d;
                    gnt_o    <= 3'b001 << win_d;
                    mem_en_o <= 1'b1;
                    busy_o   <= 1'b1;
                    last_q   <= win_d;
                    lat_q    <= CW'(MEM_LAT - 1);
                end
                ISSUE: begin
                    gnt_o    <= 3'b000;
                    mem_en_o <= 1'b0;
                    if (lat_q == '0) begin
                        state_q  <= DONE;
                        rvalid_o <= 3'b001 << sel_o;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    lat_q <= lat_q - CW'(1);
                    if (lat_q == CW'(1)) begin
                        state_q  <= DONE;
                        rvalid_o <= 3'b001 << sel_o;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    rvalid_o <= 3'b000;
                    busy_o   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus grant scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int L0 = 1;
    localparam int L1 = 3;
    typedef struct { logic [2:0] req; logic [2:0] fx; logic [2:0] rr; } vec_t;
    typedef struct { int d; logic [2:0] g; } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req    [2];
    logic [1:0] sel    [2];
    logic [2:0] gnt    [2];
    logic [2:0] rvalid [2];
    logic       mem_en [2];
    logic       busy   [2];
    int         cyc    = 0;
    int         total  = 0;
    int         passed = 0;
    exp_t       exp_q [$];
    logic [2:0] pend     [2] = '{3'b000, 3'b000};
    logic [1:0] last_sel [2] = '{2'd0, 2'd0};
    int         due      [2] = '{0, 0};
    int         rv_cyc   [2] = '{-10, -10};
    vec_t       tbl [8];

    mem_port_arbiter #(.MEM_LAT(L0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .sel_o(sel[0]), .gnt_o(gnt[0]),
        .mem_en_o(mem_en[0]), .rvalid_o(rvalid[0]), .busy_o(busy[0]));
    mem_port_arbiter #(.MEM_LAT(L1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .sel_o(sel[1]), .gnt_o(gnt[1]),
        .mem_en_o(mem_en[1]), .rvalid_o(rvalid[1]), .busy_o(busy[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [1:0] idx(input logic [2:0] g);
        return g[0] ? 2'd0 : g[1] ? 2'd1 : 2'd2;
    endfunction

    // per-cycle monitor: invariants, grant scoreboard, rvalid latency, busy, sel hold
    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk("reset_outputs", int'({sel[d], gnt[d], mem_en[d], rvalid[d], busy[d]}), 0);
                pend[d] = 3'b000;
                last_sel[d] = 2'd0;
                rv_cyc[d] = -10;
            end else begin
                chk("invariants", int'({$onehot0(gnt[d]), $onehot0(rvalid[d]),
                    !(|rvalid[d] && (|gnt[d] || mem_en[d])), mem_en[d] == |gnt[d]}), 15);
                if (|gnt[d]) begin
                    chk("gnt_while_pending", int'(pend[d]), 0);
                    chk("gnt_gap_after_rvalid", int'(cyc - rv_cyc[d] >= 2), 1);
                    if (exp_q.size() == 0 || exp_q[0].d != d) begin
                        chk("unexpected_gnt", int'(gnt[d]), 0);
                        pend[d] = gnt[d];
                        last_sel[d] = sel[d];
                    end else begin
                        e = exp_q.pop_front();
                        chk("gnt", int'(gnt[d]), int'(e.g));
                        chk("sel_at_gnt", int'(sel[d]), int'(idx(e.g)));
                        pend[d] = e.g;
                        last_sel[d] = idx(e.g);
                    end
                    due[d] = cyc + (d == 0 ? L0 : L1);
                end else begin
                    chk("sel_hold", int'(sel[d]), int'(last_sel[d]));
                end
                chk("busy", int'(busy[d]), int'(pend[d] != 3'b000));
                if (|rvalid[d]) begin
                    chk("rvalid", int'(rvalid[d]), int'(pend[d]));
                    if (pend[d] != 3'b000) chk("rvalid_latency", cyc, due[d]);
                    pend[d] = 3'b000;
                    rv_cyc[d] = cyc;
                end
            end
        end
    end

    task automatic push(input int d, input logic [2:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_q(input int left);
        int n = 0;
        while (exp_q.size() > left && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > left) begin
            total++;
            $display("FAIL grant_timeout: %0d grants outstanding, required %0d", exp_q.size(), left);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((pend[d] != 3'b000 || busy[d]) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pend[d] != 3'b000 || busy[d]) begin
            total++;
            $display("FAIL idle_timeout: dut %0d busy=%0d pending=%0d, required idle", d, busy[d], pend[d]);
        end
    endtask

    task automatic xact(input int d, input logic [2:0] r, input logic [2:0] g);
        req[d] = r;
        push(d, g);
        wait_q(0);
        req[d] = 3'b000;
        wait_idle(d);
    endtask

    initial begin
        req[0] = 3'b000;
        req[1] = 3'b000;
        // {req, fixed-priority winner, round-robin winner}; rr column assumes the
        // rotation left by the previous row, starting from last grant = 2
        tbl[0] = '{3'b010, 3'b010, 3'b010};
        tbl[1] = '{3'b001, 3'b001, 3'b001};
        tbl[2] = '{3'b100, 3'b100, 3'b100};
        tbl[3] = '{3'b110, 3'b010, 3'b010};
        tbl[4] = '{3'b101, 3'b001, 3'b100};
        tbl[5] = '{3'b011, 3'b001, 3'b001};
        tbl[6] = '{3'b110, 3'b010, 3'b010};
        tbl[7] = '{3'b100, 3'b100, 3'b100};
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                xact(d, tbl[i].req, RR ? tbl[i].rr : tbl[i].fx);
        // all requesters held for six back-to-back transactions
        for (int d = 0; d < 2; d++) begin
            req[d] = 3'b111;
            for (int k = 0; k < 6; k++) push(d, RR ? 3'(1 << (k % 3)) : 3'b001);
            wait_q(0);
            req[d] = 3'b000;
            wait_idle(d);
        end
        // requests raised mid-transaction must wait until after DONE
        push(1, 3'b100);
        push(1, 3'b001);
        req[1] = 3'b100;
        wait_q(1);
        req[1] = 3'b000;
        @(negedge clk);
        #1 req[1] = 3'b011;
        wait_q(0);
        req[1] = 3'b000;
        wait_idle(1);
        // reset during WAIT aborts the transaction with no rvalid
        push(1, 3'b010);
        req[1] = 3'b010;
        wait_q(0);
        req[1] = 3'b000;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_u1", int'({sel[1], gnt[1], mem_en[1], rvalid[1], busy[1]}), 0);
        req[1] = 3'b111;
        repeat (2) @(negedge clk);
        push(1, 3'b001);
        #1 rst_n = 1'b1;
        wait_q(0);
        req[1] = 3'b000;
        wait_idle(1);
        // request withdrawn between two rising edges: never sampled
        @(posedge clk);
        #2 req[0] = 3'b010;
        #2 req[0] = 3'b000;
        repeat (4) @(negedge clk);
        #1 chk("withdraw_busy", int'(busy[0]), 0);
        chk("withdraw_sel", int'(sel[0]), int'(last_sel[0]));
        repeat (2) @(negedge clk);
        #1 chk("drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
